ps2_scan_rx: RTL and testbench

PS/2 device-to-host receiver that deserialises keyboard frames into 8-bit scan codes and buffers them in a small FIFO. It sits directly upstream of the keyed lookup stage (scan-code-to-ASCII / segment decode). That stage consumes `data` while `ready` is high and pops entries with `nextdata_n`. The block handles synchronisation, frame validation, timeout recovery and overflow reporting.

---
 rtl/ps2_scan_rx.sv | 165 ++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scan_rx.sv
// PS/2 device-to-host receiver: synchronises the PS/2 lines, deserialises
// 11-bit frames into scan codes, validates them, and queues good codes in a
// small FIFO for the downstream lookup stage.
module ps2_scan_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       parity_err
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]    TO_MAX   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0]    TO_ONE   = TO_W'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    typedef enum logic {IDLE, RECV} state_t;

    // Line synchronisers and registered edge/bit sample
    logic [2:0] clk_sync_q;   // [0],[1] sync stages, [2] history
    logic [1:0] dat_sync_q;
    logic       fall_q;
    logic       bit_q;

    // Frame assembly
    state_t          state_q, state_d;
    logic [3:0]      bitcnt_q;
    logic [9:0]      shift_q;  // [0]=start, [8:1]=d0..d7, [9]=parity
    logic [TO_W-1:0] to_q;

    // FSM outputs
    logic frame_done;
    logic frame_valid;
    logic frame_ok;
    logic frame_bad;
    logic timeout_hit;

    // FIFO
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rptr_q, wptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               overflow_q;
    logic               parity_err_q;
    logic               pop, push, drop, full;

    // Synchronise both PS/2 lines; register the falling-edge strobe with its data bit
    always_ff @(posedge clk) begin
        if (!clrn) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
            fall_q     <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            fall_q     <= clk_sync_q[2] & ~clk_sync_q[1];
            bit_q      <= dat_sync_q[1];
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (fall_q) state_d = RECV;
            RECV: if (frame_done || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame FSM outputs: completion, validity and timeout strobes
    always_comb begin
        frame_done  = (state_q == RECV) && fall_q && (bitcnt_q == 4'd10);
        // bit_q carries the stop bit on the completing edge
        frame_valid = ~shift_q[0] & bit_q & (^shift_q[9:1]);
        frame_ok    = frame_done & frame_valid;
        frame_bad   = frame_done & ~frame_valid;
        timeout_hit = (state_q == RECV) && !fall_q && (to_q == TO_MAX);
    end

    // Bit counter, shift register and inactivity counter
    always_ff @(posedge clk) begin
        if (!clrn) begin
            bitcnt_q <= 4'd0;
            shift_q  <= 10'd0;
            to_q     <= '0;
        end else if (frame_done || timeout_hit) begin
            bitcnt_q <= 4'd0;
            to_q     <= '0;
        end else if (fall_q) begin
            shift_q  <= {bit_q, shift_q[9:1]};
            bitcnt_q <= bitcnt_q + 4'd1;
            to_q     <= '0;
        end else if (state_q == RECV) begin
            to_q <= to_q + TO_ONE;
        end else begin
            to_q <= '0;
        end
    end

    // FIFO control: a pop in the same cycle frees the slot a full push needs
    always_comb begin
        full = (count_q == CNT_FULL);
        pop  = ~nextdata_n & (count_q != '0);
        push = frame_ok & (~full | pop);
        drop = frame_ok & full & ~pop;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (push) begin
            mem_q[wptr_q] <= shift_q[8:1];
        end
    end

    // FIFO pointers, occupancy and status flags
    always_ff @(posedge clk) begin
        if (!clrn) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PTR_ONE;
            if (pop)  rptr_q <= rptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (drop) overflow_q <= 1'b1;
            parity_err_q <= frame_bad;
        end
    end

    assign data       = mem_q[rptr_q];
    assign ready      = (count_q != '0);
    assign overflow   = overflow_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// Scoreboard bench for ps2_scan_rx: the stimulus thread sends PS/2 frames and
// records the expected FIFO contents; a monitor checks every pop against them.
module tb_ps2_scan_rx;

    localparam int DEPTH = 8;
    localparam int TO    = 400;
    localparam int HALF  = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       parity_err;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_q [$];
    logic       exp_ovf = 1'b0;
    int         exp_perr = 0;
    int         perr_seen = 0;

    ps2_scan_rx #(
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (3),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .nextdata_n(nextdata_n),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: counts error pulses and checks each popped code in order
    always @(negedge clk) begin
        if (clrn) begin
            if (parity_err) perr_seen++;
            if (!nextdata_n && ready) begin
                if (model_q.size() == 0) begin
                    check("pop_unexpected_ready", {31'd0, ready}, 32'd0);
                end else begin
                    logic [7:0] e;
                    e = model_q.pop_front();
                    $display("pop data=%h expected=%h", data, e);
                    check("pop_data", {24'd0, data}, {24'd0, e});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;  // odd parity over data+parity
        return {~bad_stop, par, b, 1'b0};
    endfunction

    // Drive nbits of a frame; optionally pop on the clk edge where the stop bit lands
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit pop_at_push);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            cyc(HALF);
            ps2_clk = 1'b0;
            if (i == 10 && pop_at_push) begin
                cyc(3);
                nextdata_n = 1'b0;
                cyc(1);
                nextdata_n = 1'b1;
                cyc(HALF - 4);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    // Update the reference after a complete frame
    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (!bad_par && !bad_stop) begin
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ovf = 1'b1;
        end else begin
            exp_perr++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit pop_at_push);
        send_bits(make_frame(b, bad_par, bad_stop), 11, pop_at_push);
        cyc(HALF);
        $display("frame data=%h bad_par=%0d bad_stop=%0d pop_at_push=%0d", b, bad_par, bad_stop, pop_at_push);
        model_frame(b, bad_par, bad_stop);
    endtask

    task automatic pop_n(input int n);
        nextdata_n = 1'b0;
        cyc(n);
        nextdata_n = 1'b1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, {31'd0, model_q.size() != 0});
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        check({tag, "_parity_err_cycles"}, perr_seen, exp_perr);
        if (model_q.size() != 0) check({tag, "_data"}, {24'd0, data}, {24'd0, model_q[0]});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_data"}, {24'd0, data}, 32'h00);
        check({tag, "_ready"}, {31'd0, ready}, 32'd0);
        check({tag, "_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    endtask

    task automatic do_reset(input int n);
        clrn = 1'b0;
        cyc(n);
        model_q.delete();
        exp_ovf   = 1'b0;
        exp_perr  = 0;
        perr_seen = 0;
        clrn = 1'b1;
    endtask

    initial begin
        logic [10:0] fr;
        logic [7:0]  b;
        int          e;

        do_reset(3);
        check_reset("reset");

        // Mid-frame reset discards the partial frame and clears stored codes
        send_frame(8'h77, 1'b0, 1'b0, 1'b0);
        check_state("pre_reset");
        fr = make_frame(8'h55, 1'b0, 1'b0);
        send_bits(fr, 4, 1'b0);
        ps2_data = fr[4];
        cyc(HALF);
        ps2_clk = 1'b0;
        clrn = 1'b0;
        cyc(1);
        ps2_clk = 1'b1;
        cyc(1);
        model_q.delete();
        exp_ovf = 1'b0; exp_perr = 0; perr_seen = 0;
        clrn = 1'b1;
        ps2_data = 1'b1;
        check_reset("midframe_reset");
        cyc(TO + 50);

        // Single 0x1C frame with latency check around the stop edge
        fr = make_frame(8'h1C, 1'b0, 1'b0);
        send_bits(fr, 10, 1'b0);
        ps2_data = fr[10];
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(2);
        check("latency_early_ready", {31'd0, ready}, 32'd0);
        cyc(2);
        check("latency_ready", {31'd0, ready}, 32'd1);
        cyc(HALF - 4);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(HALF);
        $display("frame data=1c bad_par=0 bad_stop=0 pop_at_push=0");
        model_frame(8'h1C, 1'b0, 1'b0);
        check_state("single");
        pop_n(1);
        check_state("single_popped");

        // Make/break sequence, popped one by one
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
        check_state("makebreak");
        for (int i = 0; i < 3; i++) begin
            pop_n(1);
            check_state("makebreak_pop");
        end

        // Invalid frames: bad parity, then bad stop
        send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
        check_state("bad_parity");
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_state("bad_stop");

        // Pop while empty is ignored
        pop_n(2);
        check_state("pop_empty");

        // Fill, simultaneous push+pop at full, overflow, then drain
        for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
        check_state("full");
        send_frame(8'h09, 1'b0, 1'b0, 1'b1);
        check_state("full_push_pop");
        send_frame(8'h0A, 1'b0, 1'b0, 1'b0);
        check_state("overflow");
        send_frame(8'h0B, 1'b0, 1'b0, 1'b1);
        check_state("overflow_push_pop");
        pop_n(DEPTH);
        check_state("drained");

        // Timeout recovery from a stalled partial frame
        send_bits(make_frame(8'h55, 1'b0, 1'b0), 5, 1'b0);
        cyc(TO + 20);
        send_frame(8'h2A, 1'b0, 1'b0, 1'b0);
        check_state("timeout");
        pop_n(1);
        check_state("timeout_popped");

        // Randomised traffic against the reference queue
        do_reset(2);
        check_reset("reset2");
        for (int n = 0; n < 40; n++) begin
            b = 8'($urandom_range(0, 255));
            e = int'($urandom_range(0, 9));
            send_frame(b, e == 0, e == 1, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) pop_n(int'($urandom_range(1, 3)));
            check_state("rand");
        end
        pop_n(DEPTH + 1);
        check_state("rand_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
